// File: rtl/cache_control_nway_if.sv
// Bus bundle between the N-way cache controller and its CPU port, memory port and datapath.
// master = controller side, slave = environment (CPU, pmem, datapath arrays).
interface cache_control_nway_if #(
  parameter int WAYS = 4
);
  localparam int WAY_IDX = $clog2(WAYS);

  logic               mem_read;
  logic               mem_write;
  logic               mem_resp;
  logic [WAYS-1:0]    hit_vec;
  logic [WAYS-1:0]    valid_vec;
  logic [WAYS-1:0]    dirty_vec;
  logic [WAYS-2:0]    plru_bits;
  logic [WAY_IDX-1:0] way_sel;
  logic               data_sel;
  logic               pmem_addr_sel;
  logic [WAYS-1:0]    load_data;
  logic [WAYS-1:0]    load_tag;
  logic [WAYS-1:0]    load_valid;
  logic [WAYS-1:0]    load_dirty;
  logic               dirty_in;
  logic               load_plru;
  logic [WAYS-2:0]    plru_in;
  logic               pmem_resp;
  logic               pmem_read;
  logic               pmem_write;

  modport master (
    input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_bits, pmem_resp,
    output mem_resp, way_sel, data_sel, pmem_addr_sel, load_data, load_tag, load_valid,
           load_dirty, dirty_in, load_plru, plru_in, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_bits, pmem_resp,
    input  mem_resp, way_sel, data_sel, pmem_addr_sel, load_data, load_tag, load_valid,
           load_dirty, dirty_in, load_plru, plru_in, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control_nway.sv
// N-way set-associative write-back cache controller with tree pseudo-LRU and invalid-first victims.
// Optional performance counters (hit/miss/writeback) enabled by defining CACHE_PERF_CNT_EN.
module cache_control_nway #(
  parameter int WAYS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_control_nway_if.master bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
  output logic [31:0]          wb_count
`endif
);
  localparam int WAY_IDX = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE = 2'd0, EVICT = 2'd1, FILL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WAY_IDX-1:0] victim_q, victim_d;
  logic               req, is_write, hit, all_valid;
  logic [WAY_IDX-1:0] hit_way, free_way, victim_sel;
  logic [WAYS-1:0]    hit_oh, victim_oh;

  // Walk from the root: a 0 bit points left, a 1 bit points right.
  function automatic logic [WAY_IDX-1:0] plru_walk(input logic [WAYS-2:0] bits);
    logic [WAY_IDX-1:0] way;
    logic [WAY_IDX-1:0] node;
    way  = '0;
    node = '0;
    for (int l = 0; l < WAY_IDX; l++) begin
      way  = (way << 1) | WAY_IDX'(bits[node]);
      node = WAY_IDX'((1 << (l + 1)) - 1) + way;
    end
    return way;
  endfunction

  // Every node on the accessed way's path is turned to point away from it.
  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] bits,
                                                  input logic [WAY_IDX-1:0] w);
    logic [WAYS-2:0]    upd;
    logic [WAY_IDX-1:0] wt;
    logic [WAY_IDX-1:0] prefix;
    logic [WAY_IDX-1:0] node;
    logic               dir;
    upd    = bits;
    wt     = w;
    prefix = '0;
    node   = '0;
    for (int l = 0; l < WAY_IDX; l++) begin
      dir       = wt[WAY_IDX-1];
      upd[node] = ~dir;
      wt        = wt << 1;
      prefix    = (prefix << 1) | WAY_IDX'(dir);
      node      = WAY_IDX'((1 << (l + 1)) - 1) + prefix;
    end
    return upd;
  endfunction

  assign req       = bus.mem_read | bus.mem_write;
  assign is_write  = bus.mem_write;
  assign hit       = |bus.hit_vec;
  assign all_valid = &bus.valid_vec;

  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit_vec[i])    hit_way  = WAY_IDX'(i);
      if (!bus.valid_vec[i]) free_way = WAY_IDX'(i);
    end
    victim_sel = all_valid ? plru_walk(bus.plru_bits) : free_way;
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_onehot
    assign hit_oh[gi]    = (hit_way == WAY_IDX'(gi));
    assign victim_oh[gi] = (victim_q == WAY_IDX'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          victim_d = victim_sel;
          state_d  = (all_valid && bus.dirty_vec[victim_sel]) ? EVICT : FILL;
        end
      end
      EVICT:   if (bus.pmem_resp) state_d = FILL;
      FILL:    if (bus.pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so pmem strobes drop immediately.
  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.way_sel       = '0;
    bus.data_sel      = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.load_data     = '0;
    bus.load_tag      = '0;
    bus.load_valid    = '0;
    bus.load_dirty    = '0;
    bus.dirty_in      = 1'b0;
    bus.load_plru     = 1'b0;
    bus.plru_in       = '0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (req && hit) begin
            bus.mem_resp  = 1'b1;
            bus.way_sel   = hit_way;
            bus.load_plru = 1'b1;
            bus.plru_in   = plru_update(bus.plru_bits, hit_way);
            if (is_write) begin
              bus.load_data  = hit_oh;
              bus.load_dirty = hit_oh;
              bus.dirty_in   = 1'b1;
            end
          end
        end
        EVICT: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          bus.way_sel       = victim_q;
        end
        FILL: begin
          bus.pmem_read = 1'b1;
          bus.data_sel  = 1'b1;
          bus.way_sel   = victim_q;
          if (bus.pmem_resp) begin
            bus.load_data  = victim_oh;
            bus.load_tag   = victim_oh;
            bus.load_valid = victim_oh;
            bus.load_dirty = victim_oh;
          end
        end
        default: ;
      endcase
    end
  end

  a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && req) |-> $onehot0(bus.hit_vec));

`ifdef CACHE_PERF_CNT_EN
  logic miss_pending_q;
  logic miss_ev, wb_ev;

  assign miss_ev = (state_q == IDLE) && req && !hit;
  assign wb_ev   = (state_q == EVICT) && bus.pmem_resp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count      <= '0;
      miss_count     <= '0;
      wb_count       <= '0;
      miss_pending_q <= 1'b0;
    end else begin
      if (miss_ev) begin
        miss_count     <= miss_count + 32'd1;
        miss_pending_q <= 1'b1;
      end
      if (wb_ev) wb_count <= wb_count + 32'd1;
      if (bus.mem_resp) begin
        miss_pending_q <= 1'b0;
        if (!miss_pending_q) hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_control_nway.sv
// Self-checking bench for cache_control_nway (WAYS=4): hit/miss/evict flows, victim choice, async reset.
module tb_cache_control_nway;
  localparam int WAYS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_control_nway_if #(.WAYS(WAYS)) bus_if ();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  cache_control_nway #(.WAYS(WAYS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
`endif
  );

  typedef struct {
    int lat;
    int way;
    int plru_in;
    int load_data;
    int load_dirty;
    int dirty_in;
    int evict;
    int fill_tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one CPU request, plays a memory of mem_lat cycles, and checks the response.
  task automatic run_txn(input string name, input bit rd, input bit wr,
                         input logic [3:0] hv, input logic [3:0] vv, input logic [3:0] dv,
                         input logic [2:0] pb, input logic [2:0] pb_fill, input int mem_lat,
                         input exp_t e);
    exp_t       x;
    int         busy, lat;
    bit         done, saw_wr, saw_rd, path_bad;
    logic [3:0] tag_seen, valid_seen, fill_ld;
    logic       fill_din;
    busy = 0; lat = 0; done = 0; saw_wr = 0; saw_rd = 0; path_bad = 0;
    tag_seen = '0; valid_seen = '0; fill_ld = '0; fill_din = 1'b0;
    bus_if.hit_vec   = hv;
    bus_if.valid_vec = vv;
    bus_if.dirty_vec = dv;
    bus_if.plru_bits = pb;
    bus_if.pmem_resp = 1'b0;
    bus_if.mem_read  = rd;
    bus_if.mem_write = wr;
    sb_q.push_back(e);
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (bus_if.pmem_resp) begin
        bus_if.pmem_resp = 1'b0;
        busy = 0;
      end
      if (bus_if.pmem_read || bus_if.pmem_write) begin
        busy++;
        if (busy == mem_lat) bus_if.pmem_resp = 1'b1;
      end
      #1;
      if (bus_if.pmem_write) begin
        saw_wr = 1;
        if (!bus_if.pmem_addr_sel) path_bad = 1;
      end
      if (bus_if.pmem_read) begin
        saw_rd = 1;
        if (bus_if.pmem_addr_sel || !bus_if.data_sel) path_bad = 1;
        bus_if.plru_bits = pb_fill;
      end
      if (bus_if.load_tag != '0) begin
        tag_seen   |= bus_if.load_tag;
        valid_seen |= bus_if.load_valid;
        fill_ld    |= bus_if.load_data;
        fill_din    = bus_if.dirty_in;
        bus_if.hit_vec   = bus_if.load_tag;
        bus_if.valid_vec = bus_if.valid_vec | bus_if.load_tag;
        bus_if.dirty_vec = bus_if.dirty_vec & ~bus_if.load_dirty;
      end
      if (bus_if.mem_resp) begin
        done = 1;
        lat  = c;
        x    = sb_q.pop_front();
        check_val({name, "_lat"},        lat,                 x.lat);
        check_val({name, "_way"},        bus_if.way_sel,      x.way);
        check_val({name, "_load_plru"},  bus_if.load_plru,    1);
        check_val({name, "_plru_in"},    bus_if.plru_in,      x.plru_in);
        check_val({name, "_load_data"},  bus_if.load_data,    x.load_data);
        check_val({name, "_load_dirty"}, bus_if.load_dirty,   x.load_dirty);
        check_val({name, "_dirty_in"},   bus_if.dirty_in,     x.dirty_in);
        check_val({name, "_pmem_idle"},  {bus_if.pmem_read, bus_if.pmem_write}, 0);
      end
    end
    check_val({name, "_resp_seen"},  done,       1);
    check_val({name, "_writeback"},  saw_wr,     e.evict);
    check_val({name, "_fill"},       saw_rd,     (e.fill_tag != 0));
    check_val({name, "_path_sel"},   path_bad,   0);
    check_val({name, "_load_tag"},   tag_seen,   e.fill_tag);
    check_val({name, "_load_valid"}, valid_seen, e.fill_tag);
    check_val({name, "_fill_data"},  fill_ld,    e.fill_tag);
    if (e.fill_tag != 0) check_val({name, "_fill_dirty_in"}, fill_din, 0);
    $display("txn %s: rd=%0b wr=%0b latency=%0d way=%0d", name, rd, wr, lat, bus_if.way_sel);
    @(posedge clk);
    #1;
    bus_if.mem_read  = 1'b0;
    bus_if.mem_write = 1'b0;
    bus_if.pmem_resp = 1'b0;
  endtask

  initial begin
    bit got_rd;
    bus_if.mem_read  = 1'b1;
    bus_if.mem_write = 1'b0;
    bus_if.hit_vec   = 4'b0001;
    bus_if.valid_vec = 4'b1111;
    bus_if.dirty_vec = 4'b0000;
    bus_if.plru_bits = 3'b000;
    bus_if.pmem_resp = 1'b0;

    // Outputs must stay low in reset even with a hitting request present.
    @(negedge clk);
    check_val("rst_mem_resp",  bus_if.mem_resp,  0);
    check_val("rst_load_plru", bus_if.load_plru, 0);
    check_val("rst_pmem",      {bus_if.pmem_read, bus_if.pmem_write}, 0);
    $display("txn reset: mem_resp=%0b load_plru=%0b", bus_if.mem_resp, bus_if.load_plru);
    bus_if.mem_read = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn("rd_hit",     1, 0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 3'b000, 1, exp_t'{0, 2, 4, 0, 0, 0, 0, 0});
    run_txn("wr_hit",     1, 1, 4'b0001, 4'b1111, 4'b0000, 3'b000, 3'b000, 1, exp_t'{0, 0, 3, 1, 1, 1, 0, 0});
    run_txn("rd_miss",    1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b011, 3'b100, 5, exp_t'{6, 2, 4, 0, 0, 0, 0, 4});
    run_txn("inv_first",  1, 0, 4'b0000, 4'b1011, 4'b1111, 3'b000, 3'b011, 3, exp_t'{4, 2, 6, 0, 0, 0, 0, 4});
    run_txn("wr_evict",   0, 1, 4'b0000, 4'b1111, 4'b0001, 3'b000, 3'b110, 2, exp_t'{5, 0, 7, 1, 1, 1, 1, 1});
    run_txn("evict_w3",   1, 0, 4'b0000, 4'b1111, 4'b1000, 3'b101, 3'b000, 1, exp_t'{3, 3, 0, 0, 0, 0, 1, 8});
    run_txn("low_inv",    1, 0, 4'b0000, 4'b0101, 4'b1111, 3'b111, 3'b000, 2, exp_t'{3, 1, 1, 0, 0, 0, 0, 2});

`ifdef CACHE_PERF_CNT_EN
    check_val("cnt_hit",  hit_count,  2);
    check_val("cnt_miss", miss_count, 5);
    check_val("cnt_wb",   wb_count,   2);
`endif

    // No request: nothing may be enabled.
    bus_if.hit_vec = 4'b0010;
    @(negedge clk);
    #1;
    check_val("idle_resp", bus_if.mem_resp,  0);
    check_val("idle_plru", bus_if.load_plru, 0);
    check_val("idle_load", bus_if.load_data | bus_if.load_dirty, 0);
    $display("txn idle: mem_resp=%0b load_plru=%0b", bus_if.mem_resp, bus_if.load_plru);

    // Reset asserted mid-FILL.
    bus_if.hit_vec   = 4'b0000;
    bus_if.valid_vec = 4'b1111;
    bus_if.dirty_vec = 4'b0000;
    bus_if.plru_bits = 3'b000;
    bus_if.mem_read  = 1'b1;
    got_rd = 0;
    for (int c = 0; c < 10 && !got_rd; c++) begin
      @(negedge clk);
      #1;
      if (bus_if.pmem_read) got_rd = 1;
    end
    check_val("rstfill_reached", got_rd, 1);
    rst_n = 1'b0;
    #1;
    check_val("rstfill_pmem_read", bus_if.pmem_read, 0);
    bus_if.pmem_resp = 1'b1;
    #1;
    check_val("rstfill_load_tag", bus_if.load_tag | bus_if.load_valid | bus_if.load_data, 0);
    check_val("rstfill_mem_resp", bus_if.mem_resp, 0);
`ifdef CACHE_PERF_CNT_EN
    check_val("rstfill_cnt", hit_count | miss_count | wb_count, 0);
`endif
    $display("txn reset_in_fill: pmem_read=%0b load_tag=%0h", bus_if.pmem_read, bus_if.load_tag);
    bus_if.mem_read  = 1'b0;
    bus_if.pmem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn("post_rst_hit", 1, 0, 4'b1000, 4'b1111, 4'b0000, 3'b111, 3'b111, 1, exp_t'{0, 3, 2, 0, 0, 0, 0, 0});
`ifdef CACHE_PERF_CNT_EN
    check_val("post_rst_cnt_hit",  hit_count,  1);
    check_val("post_rst_cnt_miss", miss_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
